step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 The block SHALL have one clock, `clk`, and a synchronous, active-high reset, `rst`; all state SHALL update on the rising edge of `clk`.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- NPART, 4096: particles per timestep.
- PIPE_DEPTH, 8: settle cycles after the last particle retires.
- NPAIR, 512: number of solve address pairs.
- AW, 16: grid address width.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: begin a timestep.
- part_valid, in, 1: pusher offers a particle.
- part_ready, out, 1: sequencer accepts the particle.
- part_retire, in, 1: scatterer committed one particle to charge memory.
- step, out, 1: 0 = SCATTER mode, 1 = SOLVE mode; drives the scatterer mode select.
- req_valid, out, 1: solve address pair valid.
- req_addr0, out, AW: first grid address.
- req_addr1, out, AW: second grid address.
- resp_valid, in, 1: solver consumed one returned charge pair.
- busy, out, 1: timestep in progress.
- done, out, 1: one-cycle pulse at timestep end.
- err, out, 1: sticky protocol-error flag.

Function
REQ-004 The state machine SHALL have the states IDLE, SCATTER, DRAIN, FLUSH, SOLVE, WAIT and FIN.
REQ-005 In IDLE, `start`=1 SHALL clear all counters and move to SCATTER; `start` SHALL be ignored in every other state.
REQ-006 `part_ready` SHALL equal (state==SCATTER && accepted<NPART), combinationally from registered state; an accept is `part_valid`&&`part_ready`.
REQ-007 When the accept count reaches NPART, the next state SHALL be DRAIN; `part_ready` SHALL already be 0 in the cycle after the NPART-th accept.
REQ-008 The in-flight counter SHALL track particles in the pipeline:
- increment on accept;
- decrement on `part_retire`;
- stay unchanged when both occur in the same cycle.
REQ-009 A `part_retire` with in-flight==0 and no simultaneous accept SHALL set `err` and leave the counter at 0 (no wrap).
REQ-010 DRAIN SHALL hold until in-flight==0, then move to FLUSH.
REQ-011 FLUSH SHALL last exactly PIPE_DEPTH cycles, then move to SOLVE.
REQ-012 `step` SHALL be 1 in SOLVE and WAIT and 0 in all other states; it SHALL change only on FSM transitions.
REQ-013 In SOLVE, `req_valid` SHALL be 1 every cycle, with `req_addr0`=2k and `req_addr1`=2k+1 for k=0..NPAIR-1, one pair per cycle; after pair NPAIR-1 the next state SHALL be WAIT.
REQ-014 The address computation SHALL be truncated to AW bits. NPAIR*2 > 2^AW is illegal configuration and SHALL be caught by an elaboration-time assertion.
REQ-015 Responses SHALL be counted in SOLVE and WAIT. When the response count reaches NPAIR, the FSM SHALL enter FIN; this may occur in the same cycle as the last request. FIN SHALL assert `done` for one cycle and return to IDLE.
REQ-016 A `resp_valid` outside SOLVE/WAIT, or beyond NPAIR responses, SHALL set `err` and be otherwise ignored.
REQ-017 `busy` SHALL be 1 in every state except IDLE.
REQ-018 `req_valid`, `req_addr0`, `req_addr1`, `step`, `busy`, `done` and `err` SHALL be registered outputs.
REQ-019 Counter widths SHALL be $clog2(NPART+1) for accept and in-flight, $clog2(NPAIR+1) for requests and responses, and $clog2(PIPE_DEPTH+1) for flush.

Reset
REQ-020 Reset SHALL drive the following on the next edge, regardless of state:
- state=IDLE;
- all counters = 0;
- `part_ready`=0, `req_valid`=0, `req_addr0`=0, `req_addr1`=0, `step`=0, `busy`=0, `done`=0, `err`=0.
REQ-021 A reset asserted mid-timestep (any state) SHALL abort the timestep without pulsing `done`.
REQ-022 Only reset SHALL clear `err`.

Verification (NPART=4, PIPE_DEPTH=3, NPAIR=3, AW=8)
REQ-023 Nominal timestep:
- stimulus: `start`; 4 accepts with `part_valid` held high; each particle retired 5 cycles after its accept; 3 responses, each 7 cycles after its request;
- response: `part_ready` high for exactly 4 cycles; `step` rises exactly 3 cycles after the last retire; request address pairs (0,1), (2,3), (4,5) on consecutive cycles; `done` pulses once; `err`=0.
REQ-024 Simultaneous accept and retire in the same cycle -> in-flight count unchanged, and DRAIN exits only after the 4th retire.
REQ-025 Spurious retire in SCATTER with in-flight==0 -> `err`=1; `err` stays 1 through `done` and clears only on `rst`.
REQ-026 `start` pulsed during SOLVE -> ignored; exactly 3 requests are issued and `done` pulses once.
REQ-027 `rst` asserted during DRAIN -> next cycle: IDLE, all outputs 0, no `done`; a new `start` then produces a full nominal timestep.
REQ-028 All 3 responses arrive in the same cycles as their requests -> FIN is entered the cycle after the last request, and `done` pulses once.

Source files
------------

// File: rtl/step_sequencer.sv
// Timestep sequencer: admits NPART particles to the scatter pipeline, drains and
// flushes it, then issues NPAIR solve address pairs and waits for their responses.
module step_sequencer #(
    parameter int unsigned NPART      = 4096,
    parameter int unsigned PIPE_DEPTH = 8,
    parameter int unsigned NPAIR      = 512,
    parameter int unsigned AW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          part_valid,
    output logic          part_ready,
    input  logic          part_retire,
    output logic          step,
    output logic          req_valid,
    output logic [AW-1:0] req_addr0,
    output logic [AW-1:0] req_addr1,
    input  logic          resp_valid,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned AC_W = $clog2(NPART + 1);
    localparam int unsigned RQ_W = $clog2(NPAIR + 1);
    localparam int unsigned FL_W = $clog2(PIPE_DEPTH + 1);

    localparam logic [AC_W-1:0] NPART_C    = AC_W'(NPART);
    localparam logic [RQ_W-1:0] NPAIR_C    = RQ_W'(NPAIR);
    localparam logic [RQ_W-1:0] LAST_REQ_C = RQ_W'(NPAIR - 1);
    localparam logic [FL_W-1:0] LAST_FL_C  = FL_W'(PIPE_DEPTH - 1);

    // Every pair address 2k+1 must be representable in AW bits.
    if ((64'(NPAIR) * 64'd2 > (64'd1 << AW)) || (NPAIR == 0) || (PIPE_DEPTH == 0)) begin : g_cfg_check
        $error("step_sequencer: illegal configuration (NPAIR*2 exceeds 2**AW, or zero NPAIR/PIPE_DEPTH)");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCATTER,
        S_DRAIN,
        S_FLUSH,
        S_SOLVE,
        S_WAIT,
        S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AC_W-1:0] r_acc;
    logic [AC_W-1:0] w_acc_nxt;
    logic [AC_W-1:0] r_infl;
    logic [AC_W-1:0] w_infl_nxt;
    logic [RQ_W-1:0] r_req;
    logic [RQ_W-1:0] w_req_nxt;
    logic [RQ_W-1:0] r_resp;
    logic [RQ_W-1:0] w_resp_nxt;
    logic [FL_W-1:0] r_flush;
    logic [FL_W-1:0] w_flush_nxt;
    logic            w_err_set;
    logic            w_accept;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_addr0;
    logic [AW-1:0]   w_addr1;

    logic            r_step;
    logic            r_req_valid;
    logic [AW-1:0]   r_addr0;
    logic [AW-1:0]   r_addr1;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    assign part_ready = (r_state == S_SCATTER) && (r_acc < NPART_C);
    assign w_accept   = part_valid && part_ready;

    // Address pair for the request that will be visible next cycle.
    assign w_base  = AW'(w_req_nxt);
    assign w_addr0 = w_base << 1;
    assign w_addr1 = w_addr0 | AW'(1);

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_infl_nxt  = r_infl;
        w_req_nxt   = r_req;
        w_resp_nxt  = r_resp;
        w_flush_nxt = r_flush;
        w_err_set   = 1'b0;

        if (w_accept) begin
            w_acc_nxt = r_acc + AC_W'(1);
        end

        // Simultaneous accept and retire leave the in-flight count unchanged.
        if (w_accept && !part_retire) begin
            w_infl_nxt = r_infl + AC_W'(1);
        end else if (!w_accept && part_retire) begin
            if (r_infl == '0) begin
                w_err_set = 1'b1;
            end else begin
                w_infl_nxt = r_infl - AC_W'(1);
            end
        end

        if (resp_valid) begin
            if (((r_state == S_SOLVE) || (r_state == S_WAIT)) && (r_resp < NPAIR_C)) begin
                w_resp_nxt = r_resp + RQ_W'(1);
            end else begin
                w_err_set = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_nxt   = '0;
                    w_infl_nxt  = '0;
                    w_req_nxt   = '0;
                    w_resp_nxt  = '0;
                    w_flush_nxt = '0;
                    w_state_nxt = S_SCATTER;
                end
            end
            S_SCATTER: begin
                if (w_acc_nxt == NPART_C) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_flush_nxt = '0;
                if (w_infl_nxt == '0) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_flush == LAST_FL_C) begin
                    w_state_nxt = S_SOLVE;
                end else begin
                    w_flush_nxt = r_flush + FL_W'(1);
                end
            end
            S_SOLVE: begin
                w_req_nxt = r_req + RQ_W'(1);
                if (w_resp_nxt == NPAIR_C) begin
                    w_state_nxt = S_FIN;
                end else if (r_req == LAST_REQ_C) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_resp_nxt == NPAIR_C) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_infl      <= '0;
            r_req       <= '0;
            r_resp      <= '0;
            r_flush     <= '0;
            r_step      <= 1'b0;
            r_req_valid <= 1'b0;
            r_addr0     <= '0;
            r_addr1     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_infl      <= w_infl_nxt;
            r_req       <= w_req_nxt;
            r_resp      <= w_resp_nxt;
            r_flush     <= w_flush_nxt;
            r_step      <= (w_state_nxt == S_SOLVE) || (w_state_nxt == S_WAIT);
            r_req_valid <= (w_state_nxt == S_SOLVE);
            r_addr0     <= (w_state_nxt == S_SOLVE) ? w_addr0 : '0;
            r_addr1     <= (w_state_nxt == S_SOLVE) ? w_addr1 : '0;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_FIN);
            r_err       <= r_err || w_err_set;
        end
    end

    assign step      = r_step;
    assign req_valid = r_req_valid;
    assign req_addr0 = r_addr0;
    assign req_addr1 = r_addr1;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with small parameters; a cycle-level stimulus
// agent schedules retires/responses and hand-derived timing is checked per run.
module tb_step_sequencer;

    localparam int NPART = 4;
    localparam int PD    = 3;
    localparam int NPAIR = 3;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          part_valid;
    logic          part_ready;
    logic          part_retire;
    logic          step;
    logic          req_valid;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic          resp_valid;
    logic          busy;
    logic          done;
    logic          err;

    step_sequencer #(
        .NPART(NPART), .PIPE_DEPTH(PD), .NPAIR(NPAIR), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .part_valid(part_valid), .part_ready(part_ready), .part_retire(part_retire),
        .step(step), .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
        .resp_valid(resp_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit retire_at[0:511];
    bit resp_at[0:511];

    int ready_cnt, acc_cnt, last_ret, step_rise, req_cnt, first_req, last_req;
    int done_cnt, done_edge, timed_out;
    logic err_at_done;
    int req_a0[0:7];
    int req_a1[0:7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One timestep; observation happens after each edge, drives target the next edge.
    task automatic run_step(input int ret_lat, input int rsp_lat, input bit spur, input bit start_solve);
        int  t0;
        int  e;
        bit  spur_done;
        bit  solve_pulsed;
        foreach (retire_at[i]) retire_at[i] = 1'b0;
        foreach (resp_at[i]) resp_at[i] = 1'b0;
        ready_cnt = 0; acc_cnt = 0; last_ret = -1; step_rise = -1;
        req_cnt = 0; first_req = -1; last_req = -1;
        done_cnt = 0; done_edge = -1; err_at_done = 1'b0; timed_out = 0;
        spur_done = 1'b0; solve_pulsed = 1'b0;
        t0 = cyc;
        start = 1'b1;
        part_valid = 1'b0;
        tick();
        start = 1'b0;
        while (busy && (cyc - t0 < 200)) begin
            if (part_ready) ready_cnt++;
            if (step && step_rise < 0) step_rise = cyc;
            if (req_valid) begin
                if (req_cnt < 8) begin
                    req_a0[req_cnt] = int'(req_addr0);
                    req_a1[req_cnt] = int'(req_addr1);
                end
                if (req_cnt == 0) first_req = cyc;
                last_req = cyc;
                req_cnt++;
                resp_at[cyc + 1 + rsp_lat - t0] = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_edge = cyc;
                err_at_done = err;
            end
            e = cyc + 1 - t0;
            part_valid  = (acc_cnt < NPART);
            part_retire = retire_at[e];
            if (spur && !spur_done && part_ready) begin
                part_valid  = 1'b0;
                part_retire = 1'b1;
                spur_done   = 1'b1;
            end
            if (part_valid && part_ready) begin
                acc_cnt++;
                retire_at[e + ret_lat] = 1'b1;
            end
            if (part_retire) last_ret = cyc + 1;
            resp_valid = resp_at[e];
            start = start_solve && req_valid && !solve_pulsed;
            if (start) solve_pulsed = 1'b1;
            tick();
        end
        if (busy) timed_out = 1;
        start = 1'b0; part_valid = 1'b0; part_retire = 1'b0; resp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done) done_cnt++;
            tick();
        end
    endtask

    task automatic check_nominal(input string p);
        chk({p, "_timeout"}, timed_out, 0);
        chk({p, "_ready_cycles"}, ready_cnt, NPART);
        chk({p, "_step_after_retire"}, step_rise - last_ret, PD);
        chk({p, "_req_count"}, req_cnt, NPAIR);
        chk({p, "_req_consecutive"}, last_req - first_req, NPAIR - 1);
        for (int k = 0; k < NPAIR; k++) begin
            chk({p, "_addr_pair"}, (req_a0[k] << 8) | req_a1[k], ((2 * k) << 8) | (2 * k + 1));
        end
        chk({p, "_done_pulses"}, done_cnt, 1);
        chk({p, "_err"}, err, 1'b0);
        chk({p, "_busy_end"}, busy, 1'b0);
    endtask

    task automatic abort_in_drain();
        int a;
        int t0;
        int dn;
        a = 0;
        dn = 0;
        t0 = cyc;
        start = 1'b1;
        part_valid = 1'b1;
        tick();
        start = 1'b0;
        while (a < NPART && (cyc - t0 < 50)) begin
            if (part_ready && part_valid) a++;
            tick();
        end
        part_valid = 1'b0;
        chk("abort_reached_drain", a, NPART);
        chk("abort_drain_busy", busy, 1'b1);
        chk("abort_drain_ready", part_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", part_ready, 1'b0);
        chk("abort_req_valid", req_valid, 1'b0);
        chk("abort_addrs", {req_addr0, req_addr1}, 0);
        chk("abort_step", step, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_err", err, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (done) dn++;
            tick();
        end
        chk("abort_no_done", dn, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; part_valid = 1'b0; part_retire = 1'b0; resp_valid = 1'b0;
        tick();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("rst_ready", part_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_step", step, 1'b0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        run_step(5, 7, 1'b0, 1'b0);
        check_nominal("nominal");

        run_step(1, 7, 1'b0, 1'b0);
        chk("simul_timeout", timed_out, 0);
        chk("simul_step_after_retire", step_rise - last_ret, PD);
        chk("simul_err", err, 1'b0);
        chk("simul_done_pulses", done_cnt, 1);

        run_step(5, 7, 1'b0, 1'b1);
        chk("start_in_solve_timeout", timed_out, 0);
        chk("start_in_solve_req_count", req_cnt, NPAIR);
        chk("start_in_solve_done_pulses", done_cnt, 1);
        chk("start_in_solve_busy_end", busy, 1'b0);

        run_step(5, 0, 1'b0, 1'b0);
        chk("same_cycle_resp_timeout", timed_out, 0);
        chk("same_cycle_resp_req_count", req_cnt, NPAIR);
        chk("same_cycle_resp_fin_delay", done_edge - last_req, 1);
        chk("same_cycle_resp_done_pulses", done_cnt, 1);
        chk("same_cycle_resp_err", err, 1'b0);

        abort_in_drain();
        run_step(5, 7, 1'b0, 1'b0);
        check_nominal("after_abort");

        run_step(5, 7, 1'b1, 1'b0);
        chk("spur_timeout", timed_out, 0);
        chk("spur_err_at_done", err_at_done, 1'b1);
        chk("spur_done_pulses", done_cnt, 1);
        chk("spur_err_sticky", err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("spur_err_cleared_by_rst", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
